// File: rtl/sd_dat_block_serializer.sv
// SD DAT-line write serializer: start bit, payload, per-lane CRC16, end bit.
// 1-bit (DAT0) or 4-bit (DAT3..DAT0) framing, card-clock hold on FIFO underrun.
module sd_dat_block_serializer #(
    parameter int BITS   = 32,
    parameter int WCNT_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              wide_mode,
    input  logic [WCNT_W-1:0] blk_words,
    input  logic [BITS-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [3:0]        dat_out,
    output logic [3:0]        dat_oe,
    output logic              clk_hold,
    output logic              busy,
    output logic              complete
);

    localparam int SC_W = $clog2(BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_CRC,
        S_END,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic              wide_q;
    logic [WCNT_W-1:0] blk_q, fetched, loaded;
    logic [BITS-1:0]   buf_data, sh_data, cur;
    logic              buf_full;
    logic [SC_W-1:0]   sh_cnt, sh_base;
    logic [15:0]       crc [4];
    logic [3:0]        crc_cnt;
    logic [3:0]        dat_q, oe_q, lane_bit, lane_mask;
    logic              sh_empty, hold, shift_en, xfer, accept, last_shift;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        crc16_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    // An empty shift register reads straight from the buffer so reloads cost no cycle.
    assign sh_empty   = (sh_cnt == '0);
    assign cur        = sh_empty ? buf_data : sh_data;
    assign sh_base    = wide_q ? SC_W'(BITS / 4) : SC_W'(BITS);
    assign lane_mask  = wide_q ? 4'hF : 4'h1;
    assign lane_bit   = wide_q ? cur[BITS-1 -: 4] : {3'b111, cur[BITS-1]};
    assign hold       = (state == S_DATA) && sh_empty && !buf_full;
    assign shift_en   = (state == S_DATA) && !hold;
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign in_ready   = busy && !buf_full && (fetched < blk_q);
    assign xfer       = in_valid && in_ready;
    assign accept     = (state == S_IDLE) && start && (blk_words != '0);
    assign last_shift = shift_en && ((sh_empty ? sh_base : sh_cnt) == SC_W'(1)) &&
                        ((loaded + {{(WCNT_W-1){1'b0}}, sh_empty}) == blk_q);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_START;
            S_START: state_nxt = S_DATA;
            S_DATA:  if (last_shift) state_nxt = S_CRC;
            S_CRC:   if (crc_cnt == 4'd15) state_nxt = S_END;
            S_END:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dat_out  = 4'hF;
        dat_oe   = 4'h0;
        complete = 1'b0;
        clk_hold = hold;
        case (state)
            S_START: begin
                dat_out = ~lane_mask;
                dat_oe  = lane_mask;
            end
            S_DATA: begin
                if (hold) begin
                    dat_out = dat_q;
                    dat_oe  = oe_q;
                end else begin
                    dat_out = lane_bit;
                    dat_oe  = lane_mask;
                end
            end
            S_CRC: begin
                dat_out = {crc[3][15], crc[2][15], crc[1][15], crc[0][15]} | ~lane_mask;
                dat_oe  = lane_mask;
            end
            S_END:   dat_oe = lane_mask;
            S_DONE:  complete = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wide_q   <= 1'b0;
            blk_q    <= '0;
            fetched  <= '0;
            loaded   <= '0;
            buf_data <= '0;
            sh_data  <= '0;
            buf_full <= 1'b0;
            sh_cnt   <= '0;
            crc_cnt  <= '0;
            dat_q    <= 4'hF;
            oe_q     <= 4'h0;
            for (int unsigned i = 0; i < 4; i++) crc[i] <= '0;
        end else begin
            dat_q <= dat_out;
            oe_q  <= dat_oe;
            if (accept) begin
                wide_q   <= wide_mode;
                blk_q    <= blk_words;
                fetched  <= '0;
                loaded   <= '0;
                buf_full <= 1'b0;
                sh_cnt   <= '0;
            end
            if (xfer) begin
                buf_data <= in_data;
                buf_full <= 1'b1;
                fetched  <= fetched + WCNT_W'(1);
            end
            case (state)
                S_START: begin
                    crc_cnt <= '0;
                    for (int unsigned i = 0; i < 4; i++) crc[i] <= '0;
                end
                S_DATA: begin
                    if (shift_en) begin
                        sh_data <= wide_q ? (cur << 4) : (cur << 1);
                        sh_cnt  <= (sh_empty ? sh_base : sh_cnt) - SC_W'(1);
                        if (sh_empty) begin
                            buf_full <= 1'b0;
                            loaded   <= loaded + WCNT_W'(1);
                        end
                        for (int unsigned i = 0; i < 4; i++)
                            if (lane_mask[i]) crc[i] <= crc16_step(crc[i], lane_bit[i]);
                    end
                end
                S_CRC: begin
                    crc_cnt <= crc_cnt + 4'd1;
                    for (int unsigned i = 0; i < 4; i++) crc[i] <= {crc[i][14:0], 1'b0};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_dat_block_serializer.sv
// Directed bench for sd_dat_block_serializer: framing, lane mapping, CRC,
// underrun hold, mid-block reset and start filtering.
module tb_sd_dat_block_serializer;

    localparam int BITS   = 32;
    localparam int WCNT_W = 10;

    logic              clk;
    logic              reset, start, wide_mode, in_valid;
    logic [WCNT_W-1:0] blk_words;
    logic [BITS-1:0]   in_data;
    logic              in_ready, clk_hold, busy, complete;
    logic [3:0]        dat_out, dat_oe;

    sd_dat_block_serializer #(.BITS(BITS), .WCNT_W(WCNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .wide_mode(wide_mode),
        .blk_words(blk_words), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .dat_out(dat_out), .dat_oe(dat_oe),
        .clk_hold(clk_hold), .busy(busy), .complete(complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] words [128];
    logic [3:0]  rec_dat [$];
    logic [3:0]  rec_oe  [$];
    logic [3:0]  exp_dat [$];
    int          hold_cycles, cpulses;
    bit          c_after_busy, frozen_ok, timed_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        crc_step = {c[14:0], 1'b0};
        if (fb) crc_step = crc_step ^ 16'h1021;
    endfunction

    task automatic build_expected(input logic wide, input int n);
        logic [15:0] c [4];
        logic [31:0] w;
        logic [3:0]  nib;
        exp_dat.delete();
        for (int l = 0; l < 4; l++) c[l] = 16'h0000;
        exp_dat.push_back(wide ? 4'h0 : 4'hE);
        for (int wi = 0; wi < n; wi++) begin
            w = words[wi];
            if (wide) begin
                for (int k = 0; k < 8; k++) begin
                    nib = w[31-4*k -: 4];
                    exp_dat.push_back(nib);
                    for (int l = 0; l < 4; l++) c[l] = crc_step(c[l], nib[l]);
                end
            end else begin
                for (int k = 0; k < 32; k++) begin
                    exp_dat.push_back({3'b111, w[31-k]});
                    c[0] = crc_step(c[0], w[31-k]);
                end
            end
        end
        for (int k = 0; k < 16; k++) begin
            if (wide) exp_dat.push_back({c[3][15-k], c[2][15-k], c[1][15-k], c[0][15-k]});
            else      exp_dat.push_back({3'b111, c[0][15-k]});
        end
        exp_dat.push_back(4'hF);
    endtask

    task automatic compare_stream(input string tag, input logic wide, input int n);
        int mism = 0;
        int oe_mism = 0;
        int lim;
        logic [3:0] eoe;
        build_expected(wide, n);
        eoe = wide ? 4'hF : 4'h1;
        lim = (rec_dat.size() < exp_dat.size()) ? rec_dat.size() : exp_dat.size();
        check($sformatf("%s_len", tag), rec_dat.size(), exp_dat.size());
        for (int i = 0; i < lim; i++) begin
            if (rec_dat[i] !== exp_dat[i]) mism++;
            if (rec_oe[i] !== eoe) oe_mism++;
        end
        check($sformatf("%s_bits_mismatches", tag), mism, 0);
        check($sformatf("%s_oe_mismatches", tag), oe_mism, 0);
        check($sformatf("%s_timeout", tag), timed_out, 0);
    endtask

    function automatic logic [15:0] obs_crc(input int lane, input int base);
        logic [15:0] v = 16'h0000;
        logic [3:0]  s;
        for (int k = 0; k < 16; k++) begin
            if (base + k < rec_dat.size()) begin
                s = rec_dat[base + k];
                v = {v[14:0], s[lane]};
            end
        end
        return v;
    endfunction

    // Word gap_word is withheld until the gap_len-th hold cycle, giving gap_len hold cycles.
    task automatic run_block(input logic wide, input int n, input int gap_word, input int gap_len,
                             input int reset_at, input int start_at);
        int idx = 0;
        int hseen = 0;
        int cyc = 0;
        int post = 0;
        logic took, prev_busy;
        logic [3:0] last_dat;
        bit done = 0;
        rec_dat.delete();
        rec_oe.delete();
        hold_cycles = 0; cpulses = 0; c_after_busy = 0; frozen_ok = 1; timed_out = 0;
        prev_busy = 0; last_dat = 4'hF;
        @(negedge clk);
        wide_mode = wide; blk_words = WCNT_W'(n); start = 1'b1;
        in_valid = 1'b1; in_data = words[0];
        took = in_valid && in_ready;
        while (!done) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (took) idx++;
            if (busy) begin
                if (clk_hold) begin
                    hold_cycles++;
                    if (dat_out !== last_dat) frozen_ok = 0;
                end else begin
                    rec_dat.push_back(dat_out);
                    rec_oe.push_back(dat_oe);
                end
                last_dat = dat_out;
            end
            if (complete) begin
                cpulses++;
                if (prev_busy && !busy) c_after_busy = 1;
            end
            prev_busy = busy;
            if (cpulses > 0) post++;
            if (start_at != 0 && rec_dat.size() == start_at) begin
                start = 1'b1; wide_mode = ~wide; blk_words = WCNT_W'(3);
            end
            if (reset_at != 0 && rec_dat.size() == reset_at) begin
                reset = 1'b1; in_valid = 1'b0;
                @(negedge clk);
                check("reset_oe", dat_oe, 4'h0);
                check("reset_dat", dat_out, 4'hF);
                check("reset_busy", busy, 1'b0);
                reset = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    if (complete) cpulses++;
                end
                done = 1;
            end else begin
                if (idx == gap_word && clk_hold) hseen++;
                in_valid = (idx < n) && (idx != gap_word || hseen >= gap_len);
                in_data  = (idx < n) ? words[idx] : '0;
                took = in_valid && in_ready;
                if (post >= 3) done = 1;
                if (cyc > 20000) begin
                    timed_out = 1;
                    done = 1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] nibs [8];
        bit act;
        reset = 1'b1; start = 1'b0; wide_mode = 1'b0; blk_words = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check("rst_dat_out", dat_out, 4'hF);
        check("rst_dat_oe", dat_oe, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_clk_hold", clk_hold, 1'b0);
        check("rst_complete", complete, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Test 1: 1-bit, 128 x FFFFFFFF
        for (int i = 0; i < 128; i++) words[i] = 32'hFFFF_FFFF;
        run_block(1'b0, 128, -1, 0, 0, 0);
        check("t1_len_abs", rec_dat.size(), 4114);
        compare_stream("t1", 1'b0, 128);
        check("t1_crc", obs_crc(0, 4097), 16'h7FA1);
        check("t1_hold", hold_cycles, 0);
        check("t1_complete_count", cpulses, 1);
        check("t1_complete_timing", c_after_busy, 1'b1);

        // Test 2: 4-bit, 2 x 00000000
        words[0] = 32'h0; words[1] = 32'h0;
        run_block(1'b1, 2, -1, 0, 0, 0);
        check("t2_len_abs", rec_dat.size(), 34);
        compare_stream("t2", 1'b1, 2);
        check("t2_end_bit", rec_dat[33], 4'hF);
        check("t2_complete_count", cpulses, 1);

        // Test 3: lane mapping with 84210000
        words[0] = 32'h8421_0000;
        run_block(1'b1, 1, -1, 0, 0, 0);
        nibs = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int k = 0; k < 8; k++)
            check($sformatf("t3_nibble%0d", k), (k + 1 < rec_dat.size()) ? rec_dat[k+1] : 4'hX, nibs[k]);
        compare_stream("t3", 1'b1, 1);

        // Test 4: underrun at the second word boundary
        for (int i = 0; i < 128; i++) words[i] = 32'hFFFF_FFFF;
        run_block(1'b0, 128, 2, 5, 0, 0);
        check("t4_hold_cycles", hold_cycles, 5);
        check("t4_frozen", frozen_ok, 1'b1);
        compare_stream("t4", 1'b0, 128);
        check("t4_crc", obs_crc(0, 4097), 16'h7FA1);
        check("t4_complete_count", cpulses, 1);

        // Test 5: reset during CRC, then a fresh block
        words[0] = 32'hA5A5_F00F; words[1] = 32'h1234_5678;
        words[2] = 32'hDEAD_BEEF; words[3] = 32'h0000_0001;
        run_block(1'b0, 4, -1, 0, 1 + 4*32 + 5, 0);
        check("t5_no_complete", cpulses, 0);
        run_block(1'b0, 4, -1, 0, 0, 0);
        compare_stream("t5_fresh", 1'b0, 4);
        check("t5_fresh_complete", cpulses, 1);

        // Test 6: zero-length start ignored, starts while busy ignored
        act = 0;
        @(negedge clk);
        start = 1'b1; blk_words = '0;
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
            if (busy || complete || in_ready || dat_oe != 4'h0) act = 1;
        end
        check("t6_zero_blk_idle", act, 1'b0);
        for (int i = 0; i < 8; i++) words[i] = 32'h0F1E_2D3C + 32'(i * 32'h0101_0101);
        run_block(1'b0, 8, -1, 0, 0, 40);
        compare_stream("t6", 1'b0, 8);
        check("t6_single_complete", cpulses, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
